// File: rtl/binary2bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter.
// One add-3/shift step per clock, behind valid/ready handshakes.
module binary2bcd_seq_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_binary,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   packed_bcd,
    output logic [8*DIGITS-1:0]   unpacked_bcd,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   bcd_q;
    logic [BIN_W-1:0] bin_q;
    logic [BW-1:0]   packed_q;

    logic [BW-1:0]   bcd_adj;
    logic [SW-1:0]   shift_nxt;
    logic            accept;
    logic            last_step;

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_step = (state_q == SHIFT) && (cnt_q == CNT_ONE);

    // Per-digit add-3 correction; digits never carry into each other.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    assign shift_nxt = {bcd_adj, bin_q} << 1;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid)
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == CNT_ONE)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            packed_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_LOAD;
            bcd_q <= '0;
            bin_q <= in_binary;
        end else if (state_q == SHIFT) begin
            cnt_q <= cnt_q - CNT_ONE;
            bcd_q <= shift_nxt[SW-1:BIN_W];
            bin_q <= shift_nxt[BIN_W-1:0];
            if (last_step)
                packed_q <= shift_nxt[SW-1:BIN_W];
        end
    end

    assign packed_bcd = packed_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_unpack
        assign unpacked_bcd[8*i +: 8] = {4'b0000, packed_q[4*i +: 4]};
    end

endmodule

// File: tb/tb_binary2bcd_seq_ctrl.sv
// Scoreboard bench for binary2bcd_seq_ctrl.
// Expected digits come from a divide/mod-10 model.
module tb_binary2bcd_seq_ctrl;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = BIN_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BIN_W-1:0]    in_binary = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [4*DIGITS-1:0] packed_bcd;
    logic [8*DIGITS-1:0] unpacked_bcd;
    logic                busy;

    binary2bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_binary   (in_binary),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .packed_bcd  (packed_bcd),
        .unpacked_bcd(unpacked_bcd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int          acc_edge;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   last_acc = -1;
    bit   sweep = 1'b0;
    bit   ov_prev = 1'b0;

    initial begin
        if (10 ** DIGITS <= 2 ** BIN_W - 1)
            $fatal(1, "DIGITS too small for BIN_W");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] to_packed(input int unsigned v);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_unpacked(input int unsigned v);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[8*d +: 8] = 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs settle 2ns after the rising edge, sampled at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            ov_prev = 1'b0;
            last_acc = -1;
        end else begin
            if (out_valid && !ov_prev) begin
                if (q.size() == 0)
                    check("spurious_out_valid", 32'd1, 32'd0);
                else
                    check("latency", cyc - q[0].acc_edge, LAT);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check("packed", 32'(packed_bcd), to_packed(e.val));
                check("unpacked", 32'(unpacked_bcd), to_unpacked(e.val));
            end
            if (in_valid && in_ready) begin
                e.val = in_binary;
                e.acc_edge = cyc + 1;
                q.push_back(e);
                if (sweep && last_acc >= 0)
                    check("issue_interval", (cyc + 1) - last_acc, BIN_W + 2);
                last_acc = cyc + 1;
                n_acc++;
            end
            ov_prev = out_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int target);
        int to = 0;
        while (n_acc < target && to < 100) begin
            tick(1);
            to++;
        end
        if (n_acc < target)
            check("accept_timeout", 32'(n_acc), 32'(target));
    endtask

    task automatic send(input logic [BIN_W-1:0] v);
        int target = n_acc + 1;
        in_binary = v;
        in_valid  = 1'b1;
        wait_acc(target);
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        int to = 0;
        while (q.size() != 0 && to < 100) begin
            tick(1);
            to++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bit seen;
        int to;
        tick(2);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_packed", 32'(packed_bcd), 32'd0);
        check("rst_unpacked", 32'(unpacked_bcd), 32'd0);

        out_ready = 1'b1;
        send(8'd0);
        drain();
        send(8'd99);
        drain();
        send(8'd255);
        drain();

        // Backpressure holds the result and blocks new operands.
        out_ready = 1'b0;
        send(8'd173);
        to = 0;
        while (!out_valid && to < 50) begin
            tick(1);
            to++;
        end
        check("bp_reached_done", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_packed", 32'(packed_bcd), 32'h173);
            check("bp_in_ready", in_ready, 1'b0);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_idle_in_ready", in_ready, 1'b1);
        check("bp_idle_out_valid", out_valid, 1'b0);
        check("bp_hold_packed", 32'(packed_bcd), 32'h173);
        check("bp_hold_unpacked", 32'(unpacked_bcd), 32'h010703);
        check("bp_popped", 32'(q.size()), 32'd0);

        // Operand change during SHIFT is ignored until the next IDLE.
        out_ready = 1'b1;
        in_binary = 8'd42;
        in_valid  = 1'b1;
        wait_acc(n_acc + 1);
        in_binary = 8'd200;
        wait_acc(n_acc + 1);
        in_valid  = 1'b0;
        drain();

        // Reset after the third step of a conversion.
        send(8'd128);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_packed", 32'(packed_bcd), 32'd0);
        check("mid_rst_unpacked", 32'(unpacked_bcd), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick(1);
        end
        check("mid_rst_no_out_valid", seen, 1'b0);
        send(8'd7);
        drain();

        // Back-to-back sweep with the consumer always ready.
        sweep = 1'b1;
        last_acc = -1;
        in_valid = 1'b1;
        for (int v = 0; v < 256; v++) begin
            in_binary = 8'(v);
            wait_acc(n_acc + 1);
        end
        in_valid = 1'b0;
        drain();
        sweep = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
